// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID decoupling queue: instruction field
// positions, the NOP bubble and the default {PC, instruction} entry layout.
package if_id_pkg;

  localparam int INST_W = 32;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  // Entry layout for the default 32-bit PC; the queue builds the same shape
  // at its own ADDR_W.
  typedef struct packed {
    logic [31:0]       addr;
    logic [INST_W-1:0] inst;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port; contents are not reset, the owner masks them.
module if_id_fifo_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO of {PC, instruction} with a
// valid/ready fetch handshake, hazard stall on the head and branch flush.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [ADDR_W-1:0]        inst_addr_i,
  input  logic [INST_W-1:0]        inst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     hd_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic [INST_W-1:0]        inst_o,
  output logic [5:0]               op_o,
  output logic [5:0]               funct_o,
  output logic [4:0]               rs_o,
  output logic [4:0]               rt_o,
  output logic [4:0]               rd_o,
  output logic [15:0]              imm16_o,
  output logic [25:0]              jaddr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + INST_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_deq;
  entry_t           w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_data;
  entry_t           w_head;

  // Handshake status depends only on the registered count, so no input
  // reaches an output combinationally.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign in_ready_o  = !w_full;
  assign out_valid_o = !w_empty;

  assign w_enq = in_valid_i && !w_full && !flush_i;
  assign w_deq = !w_empty && !hd_i && !flush_i;

  // Pointers are log2(DEPTH) wide, so power-of-two DEPTH wraps for free.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign w_wr_entry.addr = inst_addr_i;
  assign w_wr_entry.inst = inst_i;

  if_id_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk     (clk_i),
    .i_wr_en   (w_enq),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Stale storage is masked to a NOP bubble whenever the queue is empty.
  assign w_head = out_valid_o ? entry_t'(w_rd_data)
                              : '{addr: '0, inst: NOP_INST};

  assign inst_addr_o = w_head.addr;
  assign inst_o      = w_head.inst;
  assign op_o        = w_head.inst[OP_HI:OP_LO];
  assign funct_o     = w_head.inst[FUNCT_HI:FUNCT_LO];
  assign rs_o        = w_head.inst[RS_HI:RS_LO];
  assign rt_o        = w_head.inst[RT_HI:RT_LO];
  assign rd_o        = w_head.inst[RD_HI:RD_LO];
  assign imm16_o     = w_head.inst[IMM_HI:IMM_LO];
  assign jaddr_o     = w_head.inst[JADDR_HI:JADDR_LO];
  assign count_o     = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a scoreboard queue of expected entries is
// updated as stimulus is accepted and compared against the head every cycle.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [31:0]       inst_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              hd_i;
  logic              flush_i;
  logic              out_valid_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [31:0]       inst_o;
  logic [5:0]        op_o;
  logic [5:0]        funct_o;
  logic [4:0]        rs_o;
  logic [4:0]        rt_o;
  logic [4:0]        rd_o;
  logic [15:0]       imm16_o;
  logic [25:0]       jaddr_o;
  logic [CNT_W-1:0]  count_o;

  int vectors     = 0;
  int miscompares = 0;

  if_id_entry_t sb[$];

  if_id_queue #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .inst_addr_i (inst_addr_i),
    .inst_i      (inst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .hd_i        (hd_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .inst_addr_o (inst_addr_o),
    .inst_o      (inst_o),
    .op_o        (op_o),
    .funct_o     (funct_o),
    .rs_o        (rs_o),
    .rt_o        (rt_o),
    .rd_o        (rd_o),
    .imm16_o     (imm16_o),
    .jaddr_o     (jaddr_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every output against the scoreboard head (or the NOP bubble).
  task automatic checkOutput(input string tag);
    if_id_entry_t e;
    logic         expValid;
    expValid = (sb.size() > 0);
    e = expValid ? sb[0] : '0;
    chk({tag, ".out_valid"}, 64'(out_valid_o), 64'(expValid));
    chk({tag, ".in_ready"},  64'(in_ready_o),  64'(sb.size() < DEPTH));
    chk({tag, ".count"},     64'(count_o),     64'(sb.size()));
    chk({tag, ".inst_addr"}, 64'(inst_addr_o), 64'(e.addr));
    chk({tag, ".inst"},      64'(inst_o),      64'(e.inst));
    chk({tag, ".op"},        64'(op_o),        64'(e.inst[31:26]));
    chk({tag, ".funct"},     64'(funct_o),     64'(e.inst[5:0]));
    chk({tag, ".rs"},        64'(rs_o),        64'(e.inst[25:21]));
    chk({tag, ".rt"},        64'(rt_o),        64'(e.inst[20:16]));
    chk({tag, ".rd"},        64'(rd_o),        64'(e.inst[15:11]));
    chk({tag, ".imm16"},     64'(imm16_o),     64'(e.inst[15:0]));
    chk({tag, ".jaddr"},     64'(jaddr_o),     64'(e.inst[25:0]));
  endtask

  // One clock of stimulus; the scoreboard follows the queue semantics.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] i,
                               input logic hd, input logic fl, output logic accepted);
    logic deq;
    @(negedge clk_i);
    in_valid_i  = v;
    inst_addr_i = a;
    inst_i      = i;
    hd_i        = hd;
    flush_i     = fl;
    accepted = v && (sb.size() < DEPTH) && !fl;
    deq      = (sb.size() > 0) && !hd && !fl;
    @(posedge clk_i);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (deq) void'(sb.pop_front());
      if (accepted) sb.push_back('{addr: a, inst: i});
    end
  endtask

  function automatic logic [31:0] mkInst(input int k);
    mkInst = {6'(k + 3), 5'(k + 1), 5'(k * 3), 5'(k + 7), 5'(k * 5), 6'(k + 9)};
  endfunction

  initial begin
    logic acc;
    int   k;

    rst_n_i = 1'b0;
    in_valid_i = 1'b0; inst_addr_i = '0; inst_i = '0; hd_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset");
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("post_reset");

    // First instruction: lw r2, 4(r1)
    applyStimulus(1'b1, 32'h4, 32'h8C22_0004, 1'b1, 1'b0, acc);
    chk("lw.accepted", 64'(acc), 64'(1));
    chk("lw.out_valid", 64'(out_valid_o), 64'(1));
    chk("lw.op",    64'(op_o),    64'h23);
    chk("lw.rs",    64'(rs_o),    64'h1);
    chk("lw.rt",    64'(rt_o),    64'h2);
    chk("lw.imm16", 64'(imm16_o), 64'h4);
    chk("lw.count", 64'(count_o), 64'h1);
    checkOutput("lw");

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    checkOutput("drain");

    // Three back-to-back enqueues under stall: the third must be refused.
    k = 0;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * k), mkInst(k), 1'b1, 1'b0, acc);
      if (acc) k++;
      checkOutput($sformatf("stall%0d", n));
    end
    chk("stall.third_refused", 64'(k), 64'(2));
    chk("stall.in_ready", 64'(in_ready_o), 64'(0));

    // Release the stall and keep fetching across many pointer wraps.
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * k), mkInst(k), (c % 4) == 3, 1'b0, acc);
      if (acc) k++;
      checkOutput($sformatf("wrap%0d", c));
    end
    chk("wrap.entries", 64'(k >= 10), 64'(1));

    // Simultaneous enqueue and dequeue at count 1.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    chk("simul.pre_count", 64'(count_o), 64'(1));
    applyStimulus(1'b1, 32'hA0, 32'h2001_BEEF, 1'b0, 1'b0, acc);
    chk("simul.count", 64'(count_o), 64'(1));
    chk("simul.head",  64'(inst_o),  64'h2001_BEEF);
    checkOutput("simul");

    // Fill, then flush while fetch presents an entry.
    applyStimulus(1'b1, 32'hB0, 32'h2002_1111, 1'b1, 1'b0, acc);
    checkOutput("fill");
    applyStimulus(1'b1, 32'hC0, 32'hDEAD_0001, 1'b0, 1'b1, acc);
    chk("flush_full.count", 64'(count_o), 64'(0));
    chk("flush_full.inst",  64'(inst_o),  64'(0));
    checkOutput("flush_full");

    // Flush at count 1 with ready high: the incoming entry is still dropped.
    applyStimulus(1'b1, 32'hD0, 32'h2003_2222, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'hE0, 32'hDEAD_0002, 1'b1, 1'b1, acc);
    chk("flush_one.accepted", 64'(acc), 64'(0));
    checkOutput("flush_one");
    applyStimulus(1'b1, 32'hF0, 32'h2004_3333, 1'b1, 1'b0, acc);
    chk("flush_one.next_head", 64'(inst_o), 64'h2004_3333);
    checkOutput("after_flush");

    // Fill to two, then drop reset between edges.
    applyStimulus(1'b1, 32'h110, 32'h2005_4444, 1'b1, 1'b0, acc);
    checkOutput("pre_async");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    #2;
    rst_n_i = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    applyStimulus(1'b1, 32'h120, 32'h8C22_0004, 1'b0, 1'b0, acc);
    checkOutput("post_async");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised successor to the single-entry IF/ID pipeline register. It decouples instruction fetch from decode with a DEPTH-entry FIFO of {PC, instruction} pairs and a valid/ready handshake on the fetch side. A hazard-detect stall holds the head entry, and a branch/jump flush empties the queue. Instruction fields are sliced combinationally from the head entry for the decode stage and the hazard unit.

## Interface
- ADDR_W, 32, PC width
- DEPTH, 2, queue entries; power of two, ≥2
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- inst_addr_i  in  ADDR_W  PC+4 of fetched instruction
- inst_i  in  32  fetched instruction
- in_valid_i  in  1  fetch presents an entry
- in_ready_o  out  1  queue can accept (count < DEPTH)
- hd_i  in  1  hazard stall: decode does not consume head
- flush_i  in  1  discard all entries
- out_valid_o  out  1  head entry valid
- inst_addr_o  out  ADDR_W  head PC
- inst_o  out  32  head instruction; 32'h0 (NOP) when empty
- op_o  out  6  inst[31:26]
- funct_o  out  6  inst[5:0]
- rs_o  out  5  inst[25:21]; also feeds hazard unit
- rt_o  out  5  inst[20:16]; also feeds hazard unit
- rd_o  out  5  inst[15:11]
- imm16_o  out  16  inst[15:0]
- jaddr_o  out  26  inst[25:0]
- count_o  out  $clog2(DEPTH)+1  occupancy

## Operation
- Enqueue: in_valid_i && in_ready_o && !flush_i → write at wr_ptr, wr_ptr++.
- Dequeue: out_valid_o && !hd_i && !flush_i → rd_ptr++.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy: +1 on enqueue only, −1 on dequeue only, unchanged when both occur.
- Enqueue and dequeue in the same cycle are legal whenever count ≥1 and count < DEPTH.
- When full, in_ready_o=0. There is no write-through on full.
- Flush has priority over everything. Next cycle: count=0 and pointers are zeroed. A concurrent incoming entry is dropped, and the fetch side sees the transfer as not accepted.
- hd_i only blocks dequeue. Enqueue continues until the queue is full.
- Empty: out_valid_o=0, and inst_o, all fields and inst_addr_o read 0, so decode sees a NOP bubble.
- Field outputs are purely combinational from the head entry (or the NOP constant).

## Timing
- Reset (async assert, sync release): count=0, pointers=0, out_valid_o=0, in_ready_o=1, inst_o=0, inst_addr_o=0, all fields=0. Storage contents are don't-care but masked.
- Latency: an entry accepted at edge N appears on the outputs after edge N. Minimum fill-to-decode is 1 cycle, with no combinational bypass from inst_i.
- in_ready_o and out_valid_o are functions of the registered count only. There is no combinational path from in_valid_i, hd_i or flush_i to any output.
- Reset asserted mid-operation clears the queue immediately, regardless of clk_i.

## Structure
- Package if_id_pkg:
  - field bit positions (OP_HI/LO, RS_HI/LO, RT, RD, IMM, JADDR)
  - NOP constant 32'h0
  - entry struct {addr, inst}
- Sub-module if_id_fifo_mem: DEPTH×(ADDR_W+32) register array with write port and asynchronous read port. It has no reset on the data.
- Top level holds the pointers, count, control and field slicing.

## Test plan
- Reset, then enqueue {0x4, 0x8C220004} → next cycle out_valid_o=1, op_o=0x23, rs_o=1, rt_o=2, imm16_o=0x0004, count_o=1.
- DEPTH=2: enqueue 3 back-to-back with hd_i=1 → in_ready_o=0 after the 2nd, the 3rd is held by fetch, and the head is unchanged.
- Full queue, drop hd_i, keep enqueuing → count_o alternates correctly and entries emerge in order across pointer wrap (≥3 wraps).
- flush_i with count=2 and in_valid_i=1 in the same cycle → next cycle count_o=0, out_valid_o=0, inst_o=0, and the incoming entry is absent.
- Simultaneous enqueue+dequeue at count=1 → count_o stays 1 and the head advances to the new entry.
- Assert rst_n_i low between edges while count=2 → outputs go to reset values asynchronously.
